mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/mem_arbiter_rr_arb2.sv | 25 ++
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-client read arbiter.
package mem_arbiter_pkg;

  // One bit is enough to name either read client.
  typedef logic client_id_t;

  localparam int NUM_CLIENTS  = 2;
  localparam int READ_LATENCY = 1;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: the client not granted last wins a tie,
// a lone requester always wins, and block suppresses any grant.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  client_id_t             last_id,
  input  logic                   block,
  output logic [NUM_CLIENTS-1:0] gnt
);

  // One-hot grant selection; blocked cycles grant nobody.
  always_comb begin
    gnt = '0;
    if (!block) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_id ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: two read clients arbitrated round-robin onto one
// read port, a loader client passed straight through to the write port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DATA_BITS-1:0] rdata,
  input  logic                 wreq,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 wgnt,
  output logic                 mem_r_en,
  output logic [ADDR_BITS-1:0] mem_r_addr,
  input  logic [DATA_BITS-1:0] mem_r_data,
  output logic                 mem_w_en,
  output logic [ADDR_BITS-1:0] mem_w_addr,
  output logic [DATA_BITS-1:0] mem_w_data
);

  logic [NUM_CLIENTS-1:0]  req_vec;
  logic [NUM_CLIENTS-1:0]  gnt_vec;
  client_id_t              last_id;
  client_id_t              cand_id;
  client_id_t              resp_id;
  logic [READ_LATENCY-1:0] resp_v;
  logic [ADDR_BITS-1:0]    cand_addr;
  logic                    hazard;
  logic                    accept;

  assign req_vec = {req1, req0};

  // The client that would win absent a hazard; its address alone decides
  // the read-after-write block, so a losing client is never promoted.
  assign cand_id   = (req0 && req1) ? ~last_id : req1;
  assign cand_addr = cand_id ? addr1 : addr0;
  assign hazard    = wreq && (req0 || req1) && (cand_addr == waddr);

  rr_arb2 u_rr_arb2 (
    .req     (req_vec),
    .last_id (last_id),
    .block   (hazard || !rst),
    .gnt     (gnt_vec)
  );

  assign gnt0       = gnt_vec[0];
  assign gnt1       = gnt_vec[1];
  assign accept     = gnt0 || gnt1;
  assign mem_r_en   = accept;
  assign mem_r_addr = gnt1 ? addr1 : (gnt0 ? addr0 : '0);

  // Writes are never stalled; only reset masks them.
  assign wgnt       = wreq && rst;
  assign mem_w_en   = wreq && rst;
  assign mem_w_addr = rst ? waddr : '0;
  assign mem_w_data = rst ? wdata : '0;

  // Track the accepted read one cycle ahead of its data and advance the
  // round-robin pointer only on an accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_v  <= '0;
      resp_id <= 1'b0;
      last_id <= 1'b1;
    end else begin
      resp_v  <= accept;
      resp_id <= gnt1;
      if (accept) begin
        last_id <= gnt1;
      end
    end
  end

  assign rvalid0 = rst && resp_v[READ_LATENCY-1] && !resp_id;
  assign rvalid1 = rst && resp_v[READ_LATENCY-1] && resp_id;
  assign rdata   = mem_r_data;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple synchronous memory model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, wreq;
  logic [7:0] addr0, addr1, waddr, wdata;
  logic       gnt0, gnt1, rvalid0, rvalid1, wgnt;
  logic [7:0] rdata;
  logic       mem_r_en, mem_w_en;
  logic [7:0] mem_r_addr, mem_r_data, mem_w_addr, mem_w_data;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] mem [256];
  bit         mem_init = 1'b0;

  always #5 clk = ~clk;

  // Memory model: contents start as mem[a] = a, one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end else begin
      if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
      if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    end
  end

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .wreq(wreq), .waddr(waddr), .wdata(wdata), .wgnt(wgnt),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; wreq = 1'b1;
    addr0 = 8'h10; addr1 = 8'h20; waddr = 8'h44; wdata = 8'h55;
    @(negedge clk); #1;
    vectors++; if ({gnt0, gnt1} !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1}); end
    vectors++; if (wgnt !== 1'b0) begin miscompares++; $display("FAIL reset_wgnt: got %b want 0", wgnt); end
    vectors++; if ({mem_r_en, mem_w_en} !== 2'b00) begin miscompares++; $display("FAIL reset_mem_en: got %b want 00", {mem_r_en, mem_w_en}); end
    vectors++; if ({rvalid0, rvalid1} !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1}); end
    vectors++; if ({mem_r_addr, mem_w_addr, mem_w_data} !== 24'h0) begin miscompares++; $display("FAIL reset_mem_bus: got %h want 000000", {mem_r_addr, mem_w_addr, mem_w_data}); end
  endtask

  task automatic test_contention();
    logic exp1, prev1;
    @(negedge clk);
    rst = 1'b1; wreq = 1'b0; waddr = 8'h00; wdata = 8'h00;
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h20;
    prev1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp1 = (i % 2 == 1);
      vectors++; if ({gnt1, gnt0} !== {exp1, ~exp1}) begin miscompares++; $display("FAIL contention_gnt[%0d]: got gnt1,gnt0=%b want %b", i, {gnt1, gnt0}, {exp1, ~exp1}); end
      vectors++; if (mem_r_addr !== (exp1 ? 8'h20 : 8'h10)) begin miscompares++; $display("FAIL contention_raddr[%0d]: got %h want %h", i, mem_r_addr, exp1 ? 8'h20 : 8'h10); end
      if (i > 0) begin
        vectors++; if ({rvalid1, rvalid0} !== {prev1, ~prev1}) begin miscompares++; $display("FAIL contention_rvalid[%0d]: got %b want %b", i, {rvalid1, rvalid0}, {prev1, ~prev1}); end
        vectors++; if (rdata !== (prev1 ? 8'h20 : 8'h10)) begin miscompares++; $display("FAIL contention_rdata[%0d]: got %h want %h", i, rdata, prev1 ? 8'h20 : 8'h10); end
      end
      prev1 = exp1;
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; #1;
    vectors++; if ({rvalid1, rvalid0, rdata} !== {2'b10, 8'h20}) begin miscompares++; $display("FAIL contention_last: got rv=%b rdata=%h want rv=10 rdata=20", {rvalid1, rvalid0}, rdata); end
    vectors++; if ({gnt0, gnt1, mem_r_en} !== 3'b000) begin miscompares++; $display("FAIL contention_idle: got %b want 000", {gnt0, gnt1, mem_r_en}); end
  endtask

  task automatic test_lone_requester();
    @(negedge clk);
    req1 = 1'b1; addr1 = 8'h33;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      vectors++; if ({gnt1, gnt0} !== 2'b10) begin miscompares++; $display("FAIL lone_gnt[%0d]: got %b want 10", k, {gnt1, gnt0}); end
      if (k > 0) begin
        vectors++; if ({rvalid1, rdata} !== {1'b1, 8'h33}) begin miscompares++; $display("FAIL lone_rvalid[%0d]: got rv1=%b rdata=%h want 1/33", k, rvalid1, rdata); end
      end
    end
    @(negedge clk);
    req1 = 1'b0; #1;
    vectors++; if ({rvalid1, rvalid0, rdata} !== {2'b10, 8'h33}) begin miscompares++; $display("FAIL lone_third: got rv=%b rdata=%h want 10/33", {rvalid1, rvalid0}, rdata); end
    @(negedge clk); #1;
    vectors++; if ({rvalid1, rvalid0} !== 2'b00) begin miscompares++; $display("FAIL lone_end: got %b want 00", {rvalid1, rvalid0}); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    wreq = 1'b1; waddr = 8'h05; wdata = 8'h5A; req0 = 1'b1; addr0 = 8'h05; #1;
    vectors++; if ({gnt0, mem_r_en} !== 2'b00) begin miscompares++; $display("FAIL hazard_block: got gnt0,r_en=%b want 00", {gnt0, mem_r_en}); end
    vectors++; if ({wgnt, mem_w_en} !== 2'b11) begin miscompares++; $display("FAIL hazard_write: got wgnt,w_en=%b want 11", {wgnt, mem_w_en}); end
    @(negedge clk);
    wreq = 1'b0; #1;
    vectors++; if ({gnt0, rvalid0} !== 2'b10) begin miscompares++; $display("FAIL hazard_retry: got gnt0,rv0=%b want 10", {gnt0, rvalid0}); end
    @(negedge clk);
    req0 = 1'b0; #1;
    vectors++; if ({rvalid0, rdata} !== {1'b1, 8'h5A}) begin miscompares++; $display("FAIL hazard_data: got rv0=%b rdata=%h want 1/5a", rvalid0, rdata); end
    // Client 1 is the candidate (last grant went to 0) and is blocked;
    // client 0 must not be promoted and the pointer must not move.
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h07;
    wreq = 1'b1; waddr = 8'h07; wdata = 8'h77; #1;
    vectors++; if ({gnt1, gnt0} !== 2'b00) begin miscompares++; $display("FAIL hazard_no_promote: got %b want 00", {gnt1, gnt0}); end
    @(negedge clk);
    wreq = 1'b0; #1;
    vectors++; if ({gnt1, gnt0} !== 2'b10) begin miscompares++; $display("FAIL hazard_ptr_kept: got %b want 10", {gnt1, gnt0}); end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; #1;
    vectors++; if ({rvalid1, rvalid0, rdata} !== {2'b10, 8'h77}) begin miscompares++; $display("FAIL hazard_data1: got rv=%b rdata=%h want 10/77", {rvalid1, rvalid0}, rdata); end
  endtask

  task automatic test_midflight_reset();
    @(negedge clk);
    req0 = 1'b1; addr0 = 8'h10; #1;
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL midrst_gnt0: got %b want 1", gnt0); end
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; #1;
    vectors++; if ({rvalid0, rvalid1} !== 2'b00) begin miscompares++; $display("FAIL midrst_rvalid_in_rst: got %b want 00", {rvalid0, rvalid1}); end
    @(negedge clk);
    rst = 1'b1; req1 = 1'b1; addr1 = 8'h20; #1;
    vectors++; if ({gnt1, gnt0, rvalid0} !== 3'b100) begin miscompares++; $display("FAIL midrst_after: got gnt1,gnt0,rv0=%b want 100", {gnt1, gnt0, rvalid0}); end
    @(negedge clk);
    req1 = 1'b0; #1;
    vectors++; if ({rvalid1, rvalid0, rdata} !== {2'b10, 8'h20}) begin miscompares++; $display("FAIL midrst_resp: got rv=%b rdata=%h want 10/20", {rvalid1, rvalid0}, rdata); end
  endtask

  task automatic test_write_passthrough();
    @(negedge clk);
    req0 = 1'b1; addr0 = 8'h00; wreq = 1'b1; waddr = 8'hFF; wdata = 8'hA5; #1;
    vectors++; if ({mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 8'hFF, 8'hA5}) begin miscompares++; $display("FAIL wpass_bus: got %b/%h/%h want 1/ff/a5", mem_w_en, mem_w_addr, mem_w_data); end
    vectors++; if ({wgnt, gnt0, mem_r_en, mem_r_addr} !== {3'b111, 8'h00}) begin miscompares++; $display("FAIL wpass_read: got %b/%h want 111/00", {wgnt, gnt0, mem_r_en}, mem_r_addr); end
    @(negedge clk);
    req0 = 1'b0; wreq = 1'b0; #1;
    vectors++; if ({rvalid0, rdata} !== {1'b1, 8'h00}) begin miscompares++; $display("FAIL wpass_resp: got rv0=%b rdata=%h want 1/00", rvalid0, rdata); end
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; wreq = 1'b0;
    addr0 = '0; addr1 = '0; waddr = '0; wdata = '0;
    test_reset();
    test_contention();
    test_lone_requester();
    test_hazard();
    test_midflight_reset();
    test_write_passthrough();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_arbiter
